gg_slice_parse_ctrl: RTL

Sequences the row-slice lattice parser over the bitstream word stream. It takes slice jobs (absolute byte position of each slice_layer_rbsp and the expected MB count) and fires the byte-lane slice_start trigger in the right word. It then counts macroblocks by popcount of mb_start/mb_end, detects slice_end, enforces a timeout and reports one status record per slice. It sits between the slice/start-code finder FIFO and the row-slice lattice, in parallel with the macroblock lattice.

---
 rtl/gg_slice_parse_ctrl_if.sv | 38 +++
 rtl/gg_slice_parse_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/gg_slice_parse_ctrl_if.sv
// Bitstream word, slice-job and slice-status bundle
// between the start-code FIFO, the row-slice lattice and the parse controller.
interface gg_slice_parse_ctrl_if #(
    parameter int WIDTH      = 32,
    parameter int BYTE_WIDTH = WIDTH / 8,
    parameter int MB_CNT_W   = 16
);
    logic                  in_valid;
    logic                  req_valid;
    logic                  req_ready;
    logic [31:0]           req_byte_pos;
    logic [MB_CNT_W-1:0]   req_mb_count;
    logic [BYTE_WIDTH-1:0] slice_start;
    logic [BYTE_WIDTH-1:0] slice_end;
    logic [WIDTH-1:0]      mb_start;
    logic [WIDTH-1:0]      mb_end;
    logic                  stream_hold;
    logic                  done_valid;
    logic                  done_ready;
    logic [MB_CNT_W-1:0]   done_mb_count;
    logic [31:0]           done_end_pos;
    logic [2:0]            done_err;
    logic                  busy;

    modport master (
        output in_valid, req_valid, req_byte_pos, req_mb_count,
        output slice_end, mb_start, mb_end, done_ready,
        input  req_ready, slice_start, stream_hold, done_valid,
        input  done_mb_count, done_end_pos, done_err, busy
    );

    modport slave (
        input  in_valid, req_valid, req_byte_pos, req_mb_count,
        input  slice_end, mb_start, mb_end, done_ready,
        output req_ready, slice_start, stream_hold, done_valid,
        output done_mb_count, done_end_pos, done_err, busy
    );
endinterface

// File: rtl/gg_slice_parse_ctrl.sv
// Row-slice parse sequencer: fires the slice_start lane, counts MBs,
// detects slice_end or timeout and emits one status record per slice.
module gg_slice_parse_ctrl #(
    parameter int WIDTH         = 32,
    parameter int BYTE_WIDTH    = WIDTH / 8,
    parameter int MB_CNT_W      = 16,
    parameter int TIMEOUT_WORDS = 1024
) (
    input logic                  clk,
    input logic                  reset,
    gg_slice_parse_ctrl_if.slave bus
);
    localparam int LW  = (BYTE_WIDTH > 1) ? $clog2(BYTE_WIDTH) : 1;
    localparam int PCW = $clog2(WIDTH + 1);
    localparam int TW  = $clog2(TIMEOUT_WORDS + 1);
    localparam logic [BYTE_WIDTH-1:0] LANE1 = BYTE_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, WAIT_POS, ACTIVE, DONE} state_e;

    state_e                state_q;
    logic [31:0]           base_q;
    logic [31:0]           pos_q;
    logic [MB_CNT_W-1:0]   cnt_q;
    logic [MB_CNT_W-1:0]   mb_cnt_q;
    logic [MB_CNT_W-1:0]   end_cnt_q;
    logic [TW-1:0]         timer_q;
    logic                  rdy_q;
    logic                  dv_q;
    logic                  hold_q;
    logic                  busy_q;
    logic [MB_CNT_W-1:0]   dmb_q;
    logic [31:0]           dend_q;
    logic [2:0]            derr_q;

    logic [31:0]           off;
    logic [31:0]           late_diff;
    logic [31:0]           end_pos;
    logic                  hit;
    logic                  work;
    logic                  late;
    logic                  progress;
    logic [LW-1:0]         start_lane;
    logic [LW-1:0]         hi_lane;
    logic [BYTE_WIDTH-1:0] end_mask;
    logic [BYTE_WIDTH-1:0] se_m;
    logic [MB_CNT_W-1:0]   mb_sum_d;
    logic [MB_CNT_W-1:0]   end_sum_d;
    logic [TW-1:0]         timer_d;

    function automatic logic [PCW-1:0] popcnt(input logic [WIDTH-1:0] v);
        logic [PCW-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) n = n + PCW'(v[i]);
        return n;
    endfunction

    function automatic logic [MB_CNT_W-1:0] sat_add(
        input logic [MB_CNT_W-1:0] a,
        input logic [PCW-1:0]      b
    );
        logic [MB_CNT_W:0] s;
        s = {1'b0, a} + (MB_CNT_W+1)'(b);
        return s[MB_CNT_W] ? '1 : s[MB_CNT_W-1:0];
    endfunction

    assign off        = pos_q - base_q;
    assign start_lane = LW'(BYTE_WIDTH - 1) - off[LW-1:0];
    assign hit        = (state_q == WAIT_POS) && bus.in_valid
                        && (off < 32'(BYTE_WIDTH));
    assign work       = bus.in_valid && (hit || state_q == ACTIVE);

    // In the start word only lanes after the trigger byte belong to this slice
    assign end_mask   = hit ? (LANE1 << start_lane) - LANE1 : '1;
    assign se_m       = bus.slice_end & end_mask;
    assign progress   = |{bus.mb_start, bus.mb_end};
    assign late_diff  = base_q - bus.req_byte_pos;
    assign late       = (late_diff != '0) && !late_diff[31];
    assign mb_sum_d   = sat_add(mb_cnt_q, popcnt(bus.mb_start));
    assign end_sum_d  = sat_add(end_cnt_q, popcnt(bus.mb_end));
    assign timer_d    = progress ? '0 : timer_q + TW'(1);
    assign end_pos    = base_q + 32'(BYTE_WIDTH - 1) - 32'(hi_lane);

    always_comb begin
        hi_lane = '0;
        for (int l = 0; l < BYTE_WIDTH; l++) begin
            if (se_m[l]) hi_lane = LW'(l);
        end
    end

    assign bus.slice_start   = hit ? (LANE1 << start_lane) : '0;
    assign bus.req_ready     = rdy_q;
    assign bus.done_valid    = dv_q;
    assign bus.stream_hold   = hold_q;
    assign bus.busy          = busy_q;
    assign bus.done_mb_count = dmb_q;
    assign bus.done_end_pos  = dend_q;
    assign bus.done_err      = derr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            base_q    <= '0;
            pos_q     <= '0;
            cnt_q     <= '0;
            mb_cnt_q  <= '0;
            end_cnt_q <= '0;
            timer_q   <= '0;
            rdy_q     <= 1'b0;
            dv_q      <= 1'b0;
            hold_q    <= 1'b0;
            busy_q    <= 1'b0;
            dmb_q     <= '0;
            dend_q    <= '0;
            derr_q    <= '0;
        end else begin
            if (bus.in_valid) base_q <= base_q + 32'(BYTE_WIDTH);
            unique case (state_q)
                IDLE: begin
                    rdy_q <= 1'b1;
                    if (bus.req_valid && rdy_q) begin
                        pos_q     <= bus.req_byte_pos;
                        cnt_q     <= bus.req_mb_count;
                        mb_cnt_q  <= '0;
                        end_cnt_q <= '0;
                        timer_q   <= '0;
                        rdy_q     <= 1'b0;
                        busy_q    <= 1'b1;
                        if (late) begin
                            state_q <= DONE;
                            dv_q    <= 1'b1;
                            hold_q  <= 1'b1;
                            dmb_q   <= '0;
                            dend_q  <= '0;
                            derr_q  <= 3'b100;
                        end else begin
                            state_q <= WAIT_POS;
                        end
                    end
                end
                WAIT_POS, ACTIVE: begin
                    if (work) begin
                        state_q   <= ACTIVE;
                        mb_cnt_q  <= mb_sum_d;
                        end_cnt_q <= end_sum_d;
                        timer_q   <= timer_d;
                        if (|se_m) begin
                            state_q <= DONE;
                            dv_q    <= 1'b1;
                            hold_q  <= 1'b1;
                            dmb_q   <= mb_sum_d;
                            dend_q  <= end_pos;
                            derr_q  <= {2'b00, mb_sum_d != cnt_q};
                        end else if (timer_d == TW'(TIMEOUT_WORDS)) begin
                            state_q <= DONE;
                            dv_q    <= 1'b1;
                            hold_q  <= 1'b1;
                            dmb_q   <= mb_sum_d;
                            dend_q  <= '0;
                            derr_q  <= 3'b010;
                        end
                    end
                end
                DONE: begin
                    if (bus.done_ready) begin
                        state_q <= IDLE;
                        dv_q    <= 1'b0;
                        hold_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        rdy_q   <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule
